alu_seq_core: RTL and testbench

Parametrised sequential ALU core: a WIDTH-bit, NREGS-entry register file, a carry/zero flag pair and a 16-operation ALU, sequenced by a four-state FSM with a start/busy/done handshake. It is the next-generation operand/ALU engine of the CPU datapath. The host loads registers, issues a three-address operation, and reads results back through an asynchronous read port.

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq_datapath.sv | 72 +++++++
 rtl/alu_seq_core.sv | 111 +++++++++++
 tb/tb_alu_seq_core.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU core: op codes, FSM states and
// a helper that tells which ops treat the carry flag as a borrow.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_ROL  = 4'hA,
        OP_ROR  = 4'hB,
        OP_INC  = 4'hC,
        OP_DEC  = 4'hD,
        OP_PASS = 4'hE,
        OP_CMP  = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Ops whose carry-out is a borrow (set when the true result is negative).
    function automatic logic is_borrow_op(alu_op_t op);
        return (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Host-side bus of the sequential ALU core.
//
// Handshake: with ce=1 in IDLE, load=1 writes data_in to regs[dst]
// (load wins over start). Otherwise start=1 launches op; busy rises
// on the next cycle and stays high until the op retires. done pulses
// for the single WB cycle (held while ce=0 stalls WB). op, dst, srca
// and srcb must stay stable until the READ cycle has been clocked.
// load/start seen while busy are dropped, never queued.
interface alu_seq_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic                  ce;
    logic                  load;
    logic                  start;
    logic [3:0]            op;
    logic [AW-1:0]         dst;
    logic [AW-1:0]         srca;
    logic [AW-1:0]         srcb;
    logic [WIDTH-1:0]      data_in;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [WIDTH-1:0]      data_out;
    logic                  cout;
    logic                  zero;
    logic                  busy;
    logic                  done;
    alu_seq_pkg::state_t   state;

    modport master (
        output ce, load, start, op, dst, srca, srcb, data_in, rd_addr,
        input  rd_data, data_out, cout, zero, busy, done, state
    );

    modport slave (
        input  ce, load, start, op, dst, srca, srcb, data_in, rd_addr,
        output rd_data, data_out, cout, zero, busy, done, state
    );
endinterface

// File: rtl/alu_seq_datapath.sv
// Combinational ALU: computes a WIDTH+1 bit result whose top bit is the
// candidate carry/borrow, plus whether the op is allowed to update C.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic             c_next,
    output logic             c_upd,
    output logic             z_next
);

    logic [WIDTH:0] lhs;
    logic [WIDTH:0] rhs;
    logic [WIDTH:0] cin_x;
    logic [WIDTH:0] arith;
    logic [WIDTH:0] ext;

    // Shared adder/subtractor operands: INC/DEC use a constant one,
    // ADC/SBB fold in the current carry.
    always_comb begin
        lhs   = {1'b0, a};
        rhs   = {1'b0, b};
        cin_x = '0;
        if (op == OP_INC || op == OP_DEC) begin
            rhs = {{WIDTH{1'b0}}, 1'b1};
        end
        if (op == OP_ADC || op == OP_SBB) begin
            cin_x = {{WIDTH{1'b0}}, c};
        end
    end

    // Widened arithmetic: bit WIDTH is the carry for adds and the borrow for subtracts.
    always_comb begin
        arith = '0;
        if (is_borrow_op(op)) begin
            arith = lhs - rhs - cin_x;
        end else begin
            arith = lhs + rhs + cin_x;
        end
    end

    // Op selection; shifts and rotates place the outgoing bit at the top.
    always_comb begin
        ext   = '0;
        c_upd = 1'b1;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB,
            OP_INC, OP_DEC, OP_CMP: ext = arith;
            OP_AND:  begin ext = {1'b0, a & b}; c_upd = 1'b0; end
            OP_OR:   begin ext = {1'b0, a | b}; c_upd = 1'b0; end
            OP_XOR:  begin ext = {1'b0, a ^ b}; c_upd = 1'b0; end
            OP_NOT:  begin ext = {1'b0, ~a};    c_upd = 1'b0; end
            OP_SHL:  ext = {a, 1'b0};
            OP_SHR:  ext = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_ROL:  ext = {a, c};
            OP_ROR:  ext = {a[0], c, a[WIDTH-1:1]};
            OP_PASS: begin ext = {1'b0, a};     c_upd = 1'b0; end
            default: begin ext = '0;            c_upd = 1'b0; end
        endcase
    end

    assign result = ext[WIDTH-1:0];
    assign c_next = ext[WIDTH];
    assign z_next = (ext[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU core: register file, C/Z flags and a four-state
// IDLE->READ->EXEC->WB sequencer. Operands are latched in READ so the
// destination may alias a source; the write lands at the end of WB.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);

    logic [WIDTH-1:0] regs [NREGS];
    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    alu_op_t          op_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] dout_q;
    logic             c_q;
    logic             z_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] alu_result;
    logic             alu_c_next;
    logic             alu_c_upd;
    logic             alu_z_next;

    alu_seq_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .op     (op_q),
        .result (alu_result),
        .c_next (alu_c_next),
        .c_upd  (alu_c_upd),
        .z_next (alu_z_next)
    );

    // Sequencer, register file and flags; everything holds while ce=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_ADD;
            dst_q  <= '0;
            dout_q <= '0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (bus.ce) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        regs[bus.dst] <= bus.data_in;
                    end else if (bus.start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    a_q     <= regs[bus.srca];
                    b_q     <= regs[bus.srcb];
                    op_q    <= alu_op_t'(bus.op);
                    dst_q   <= bus.dst;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    dout_q <= alu_result;
                    if (alu_c_upd) begin
                        c_q <= alu_c_next;
                    end
                    z_q     <= alu_z_next;
                    done_q  <= 1'b1;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (op_q != OP_CMP) begin
                        regs[dst_q] <= dout_q;
                    end
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data  = regs[bus.rd_addr];
    assign bus.data_out = dout_q;
    assign bus.cout     = c_q;
    assign bus.zero     = z_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed scenarios plus randomized ops checked
// against an integer-arithmetic reference model.
module tb_alu_seq_core;
    import alu_seq_pkg::*;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;

    // Clock and reset
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W), .AW(AW)) bus ();

    alu_seq_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int num_cmp  = 0;
    int num_fail = 0;

    // Reference model state
    longint m_regs [N];
    bit     m_c;
    bit     m_z;
    longint m_dout;
    logic [W-1:0] exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        m_c = 0; m_z = 0; m_dout = 0;
    endfunction

    function automatic void model_exec(alu_op_t o, int d, int sa, int sb);
        longint m, a, b, t;
        bit nc;
        bit keep;
        m = longint'(1) << W;
        a = m_regs[sa];
        b = m_regs[sb];
        t = 0;
        nc = m_c;
        keep = 0;
        case (o)
            OP_ADD:  begin t = a + b;          nc = (t >= m); end
            OP_ADC:  begin t = a + b + m_c;    nc = (t >= m); end
            OP_SUB:  begin t = a - b;          nc = (t < 0);  end
            OP_SBB:  begin t = a - b - m_c;    nc = (t < 0);  end
            OP_AND:  begin t = a & b;          keep = 1; end
            OP_OR:   begin t = a | b;          keep = 1; end
            OP_XOR:  begin t = a ^ b;          keep = 1; end
            OP_NOT:  begin t = m - 1 - a;      keep = 1; end
            OP_SHL:  begin t = a * 2;          nc = (a >= m / 2); end
            OP_SHR:  begin t = a / 2;          nc = (a % 2 == 1); end
            OP_ROL:  begin t = a * 2 + m_c;    nc = (a >= m / 2); end
            OP_ROR:  begin t = a / 2 + m_c * (m / 2); nc = (a % 2 == 1); end
            OP_INC:  begin t = a + 1;          nc = (t >= m); end
            OP_DEC:  begin t = a - 1;          nc = (t < 0);  end
            OP_PASS: begin t = a;              keep = 1; end
            default: begin t = a - b;          nc = (t < 0);  end
        endcase
        m_dout = ((t % m) + m) % m;
        if (!keep) m_c = nc;
        m_z = (m_dout == 0);
        if (o != OP_CMP) m_regs[d] = m_dout;
    endfunction

    // Driver tasks
    task automatic do_load(input logic [AW-1:0] d, input logic [W-1:0] v);
        @(negedge clk);
        bus.ce = 1'b1; bus.load = 1'b1; bus.start = 1'b0;
        bus.dst = d; bus.data_in = v;
        @(negedge clk);
        bus.load = 1'b0;
        m_regs[d] = v;
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [W-1:0] v);
        bus.rd_addr = a;
        #1;
        v = bus.rd_data;
    endtask

    // Issues one op; lat counts falling edges after the start edge until done.
    task automatic run_op(input alu_op_t o, input logic [AW-1:0] d, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input int stall_at, input int stall_len,
                          input bit hold_start, output int lat, output logic [W-1:0] dout,
                          output logic c, output logic z, output logic busy_after,
                          output logic done_after);
        model_exec(o, d, sa, sb);
        @(negedge clk);
        bus.ce = 1'b1; bus.load = 1'b0; bus.start = 1'b1;
        bus.op = o; bus.dst = d; bus.srca = sa; bus.srcb = sb;
        lat = -1; dout = 'x; c = 1'bx; z = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n; dout = bus.data_out; c = bus.cout; z = bus.zero;
                break;
            end
            bus.start = hold_start;
            bus.ce = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
        end
        bus.start = 1'b0; bus.ce = 1'b1;
        @(negedge clk);
        busy_after = bus.busy; done_after = bus.done;
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        @(negedge clk); rst = 1'b1;
        do_load(3, 8'h11);
        @(negedge clk);
        bus.op = OP_ADD; bus.dst = 3; bus.srca = 3; bus.srcb = 3; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        rst = 1'b0; #1;
        num_cmp++; if (bus.busy !== 1'b0) begin num_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        num_cmp++; if (bus.done !== 1'b0) begin num_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        num_cmp++; if (bus.data_out !== 8'h00) begin num_fail++; $display("FAIL reset_dout: got %h expected 00", bus.data_out); end
        @(negedge clk); rst = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            read_reg(AW'(i), v);
            num_cmp++; if (v !== 8'h00) begin num_fail++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
        end
        do_load(1, 8'h7F);
        do_load(2, 8'h01);
        read_reg(1, v);
        num_cmp++; if (v !== 8'h7F) begin num_fail++; $display("FAIL load_r1: got %h expected 7f", v); end
        read_reg(2, v);
        num_cmp++; if (v !== 8'h01) begin num_fail++; $display("FAIL load_r2: got %h expected 01", v); end
        num_cmp++; if (bus.busy !== 1'b0) begin num_fail++; $display("FAIL load_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_add_adc();
        int lat; logic [W-1:0] dout, v; logic c, z, ba, da;
        run_op(OP_ADD, 3, 1, 2, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (lat !== 3) begin num_fail++; $display("FAIL add_latency: got %0d expected 3", lat); end
        num_cmp++; if (dout !== 8'h80) begin num_fail++; $display("FAIL add_dout: got %h expected 80", dout); end
        num_cmp++; if (c !== 1'b0 || z !== 1'b0) begin num_fail++; $display("FAIL add_flags: got c=%b z=%b expected c=0 z=0", c, z); end
        num_cmp++; if (ba !== 1'b0 || da !== 1'b0) begin num_fail++; $display("FAIL add_retire: got busy=%b done=%b expected 0 0", ba, da); end
        read_reg(3, v);
        num_cmp++; if (v !== 8'h80) begin num_fail++; $display("FAIL add_r3: got %h expected 80", v); end
        do_load(4, 8'hFF);
        run_op(OP_ADC, 5, 4, 2, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (lat !== 3) begin num_fail++; $display("FAIL adc_latency: got %0d expected 3", lat); end
        num_cmp++; if (dout !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin num_fail++; $display("FAIL adc_result: got %h c=%b z=%b expected 00 c=1 z=1", dout, c, z); end
        read_reg(5, v);
        num_cmp++; if (v !== 8'h00) begin num_fail++; $display("FAIL adc_r5: got %h expected 00", v); end
    endtask

    task automatic test_sub_cmp();
        int lat; logic [W-1:0] dout, v; logic c, z, ba, da;
        run_op(OP_SUB, 6, 2, 1, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (dout !== 8'h82 || c !== 1'b1 || z !== 1'b0) begin num_fail++; $display("FAIL sub_result: got %h c=%b z=%b expected 82 c=1 z=0", dout, c, z); end
        read_reg(6, v);
        num_cmp++; if (v !== 8'h82) begin num_fail++; $display("FAIL sub_r6: got %h expected 82", v); end
        run_op(OP_CMP, 6, 1, 1, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (z !== 1'b1 || c !== 1'b0) begin num_fail++; $display("FAIL cmp_flags: got c=%b z=%b expected c=0 z=1", c, z); end
        read_reg(6, v);
        num_cmp++; if (v !== 8'h82) begin num_fail++; $display("FAIL cmp_nowrite: got %h expected 82", v); end
    endtask

    task automatic test_rol_chain();
        int lat; logic [W-1:0] dout, v; logic c, z, ba, da;
        do_load(1, 8'h80);
        do_load(7, 8'h80);
        run_op(OP_SHL, 7, 7, 7, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (c !== 1'b1 || dout !== 8'h00) begin num_fail++; $display("FAIL shl_setc: got %h c=%b expected 00 c=1", dout, c); end
        run_op(OP_ROL, 1, 1, 1, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (dout !== 8'h01 || c !== 1'b1) begin num_fail++; $display("FAIL rol1: got %h c=%b expected 01 c=1", dout, c); end
        run_op(OP_ROL, 1, 1, 1, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (dout !== 8'h03 || c !== 1'b0) begin num_fail++; $display("FAIL rol2: got %h c=%b expected 03 c=0", dout, c); end
        read_reg(1, v);
        num_cmp++; if (v !== 8'h03) begin num_fail++; $display("FAIL rol_r1: got %h expected 03", v); end
    endtask

    task automatic test_handshake();
        int lat; logic [W-1:0] dout, v; logic c, z, ba, da;
        // start held high through the whole op: only one op may run
        run_op(OP_ADD, 0, 1, 2, 0, 0, 1, lat, dout, c, z, ba, da);
        num_cmp++; if (lat !== 3 || dout !== 8'h04) begin num_fail++; $display("FAIL busy_start_op: got lat=%0d %h expected lat=3 04", lat, dout); end
        num_cmp++; if (ba !== 1'b0) begin num_fail++; $display("FAIL busy_start_retire: got busy=%b expected 0", ba); end
        @(negedge clk);
        num_cmp++; if (bus.busy !== 1'b0) begin num_fail++; $display("FAIL busy_start_requeue: got busy=%b expected 0", bus.busy); end
        // load and start together: only the load happens
        @(negedge clk);
        bus.load = 1'b1; bus.start = 1'b1; bus.dst = 2; bus.data_in = 8'h5A;
        bus.op = OP_ADD; bus.srca = 1; bus.srcb = 1;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        m_regs[2] = 8'h5A;
        num_cmp++; if (bus.busy !== 1'b0) begin num_fail++; $display("FAIL load_start_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        num_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin num_fail++; $display("FAIL load_start_noop: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        read_reg(2, v);
        num_cmp++; if (v !== 8'h5A) begin num_fail++; $display("FAIL load_start_r2: got %h expected 5a", v); end
        // ce low for three cycles while in EXEC
        run_op(OP_XOR, 3, 1, 2, 2, 3, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (lat !== 6) begin num_fail++; $display("FAIL ce_stall_latency: got %0d expected 6", lat); end
        num_cmp++; if (dout !== 8'h59 || c !== 1'b0 || z !== 1'b0) begin num_fail++; $display("FAIL ce_stall_result: got %h c=%b z=%b expected 59 c=0 z=0", dout, c, z); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [W-1:0] dout, v; logic c, z, ba, da;
        run_op(OP_ADD, 5, 4, 2, 0, 0, 0, lat, dout, c, z, ba, da);
        num_cmp++; if (c !== 1'b1 || dout !== 8'h59) begin num_fail++; $display("FAIL pre_reset_carry: got %h c=%b expected 59 c=1", dout, c); end
        do_load(7, 8'h55);
        @(negedge clk);
        bus.op = OP_ADD; bus.dst = 7; bus.srca = 4; bus.srcb = 4; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0; #1;
        num_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin num_fail++; $display("FAIL midop_hs: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        num_cmp++; if (bus.cout !== 1'b0 || bus.zero !== 1'b0) begin num_fail++; $display("FAIL midop_flags: got c=%b z=%b expected 0 0", bus.cout, bus.zero); end
        num_cmp++; if (bus.data_out !== 8'h00) begin num_fail++; $display("FAIL midop_dout: got %h expected 00", bus.data_out); end
        @(negedge clk); rst = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        read_reg(7, v);
        num_cmp++; if (v !== 8'h00) begin num_fail++; $display("FAIL midop_r7: got %h expected 00", v); end
        num_cmp++; if (bus.busy !== 1'b0) begin num_fail++; $display("FAIL midop_idle: got busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] dout, v, e; logic c, z, ba, da;
        alu_op_t o; logic [AW-1:0] d, sa, sb; int sl, sat;
        for (int i = 0; i < N; i++) do_load(AW'(i), W'($urandom_range(0, 255)));
        for (int k = 0; k < 60; k++) begin
            o   = alu_op_t'($urandom_range(0, 15));
            d   = AW'($urandom_range(0, N - 1));
            sa  = AW'($urandom_range(0, N - 1));
            sb  = AW'($urandom_range(0, N - 1));
            sl  = $urandom_range(0, 2);
            sat = $urandom_range(1, 2);
            run_op(o, d, sa, sb, sat, sl, 0, lat, dout, c, z, ba, da);
            exp_q.push_back(W'(m_dout));
            e = exp_q.pop_front();
            num_cmp++; if (dout !== e || c !== m_c || z !== m_z) begin num_fail++; $display("FAIL rand%0d_%s: got %h c=%b z=%b expected %h c=%b z=%b", k, o.name(), dout, c, z, e, m_c, m_z); end
            num_cmp++; if (lat !== 3 + sl) begin num_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, 3 + sl); end
            read_reg(d, v);
            num_cmp++; if (v !== W'(m_regs[d])) begin num_fail++; $display("FAIL rand%0d_reg%0d: got %h expected %h", k, d, v, W'(m_regs[d])); end
        end
    endtask

    // Test sequence and final report
    initial begin
        rst = 1'b0;
        bus.ce = 1'b1; bus.load = 1'b0; bus.start = 1'b0; bus.op = 4'h0;
        bus.dst = '0; bus.srca = '0; bus.srcb = '0; bus.data_in = '0; bus.rd_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_add_adc();
        test_sub_cmp();
        test_rol_chain();
        test_handshake();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_fail);
        $finish;
    end

endmodule
